// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit
// Instruction-fetch front end. It owns the fetch PC and sends pipelined
// requests to instruction memory. Responses are buffered in a DEPTH-entry
// FIFO, and {pc, instr} pairs go to decode over a valid/ready handshake.
// A redirect (taken branch/jump) restarts fetch at a new target. Responses
// still in flight at that point are dropped as they arrive.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   imem_req_valid    request valid (out)
//   imem_req_ready    memory accepts the request this cycle (in)
//   imem_addr         request address, equal to the fetch PC (out)
//   imem_rsp_valid    in-order response valid (in)
//   imem_rsp_data     response instruction word (in)
//   redirect_valid    restart fetch at redirect_pc (in)
//   redirect_pc       redirect target (in)
//   out_valid         FIFO head valid (out)
//   out_ready         decode consumes the head (in)
//   out_instr/out_pc  FIFO head contents; both are zero when out_valid=0 (out)
//   misaligned_err    one-cycle pulse after a redirect with pc[1:0]!=0 (out)
module rv_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            misaligned_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   occ, outst, drop;
  logic [CW-1:0]   outst_n, drop_n;

  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [31:0]     fifo_instr [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  // PCs of requests still in flight, in issue order. Responses come back
  // in order, so the head always belongs to the next response.
  logic [XLEN-1:0] pcq [DEPTH];
  logic [AW-1:0]   pcq_wr, pcq_rd;

  logic credit_ok, accept, rsp_ok, push, pop;

  // Credit rule: a new request is only allowed while buffered entries plus
  // in-flight requests leave room. Every response then has a FIFO slot.
  assign credit_ok      = ({1'b0, occ} + {1'b0, outst}) < DEPTH_W;
  assign imem_req_valid = !rst && (state == RUN) && credit_ok && !redirect_valid;
  assign imem_addr      = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_ok         = imem_rsp_valid && (outst != '0);
  assign push           = rsp_ok && !redirect_valid && (state == RUN);

  assign out_valid = !rst && (occ != '0);
  assign pop       = out_valid && out_ready;
  assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : '0;
  assign out_instr = out_valid ? fifo_instr[rd_ptr] : '0;

  // On redirect, the drop count is the outstanding count after this
  // cycle's accept and response. Only responses still to arrive get dropped.
  always_comb begin
    outst_n = outst;
    if (accept) outst_n = outst_n + CW'(1);
    if (rsp_ok) outst_n = outst_n - CW'(1);

    drop_n = drop;
    if (redirect_valid)
      drop_n = outst_n;
    else if ((state == FLUSH) && rsp_ok && (drop != '0))
      drop_n = drop - CW'(1);

    state_n = state;
    if (redirect_valid)
      state_n = (outst_n == '0) ? RUN : FLUSH;
    else if ((state == FLUSH) && (drop_n == '0))
      state_n = RUN;
  end

  // Main state. Reset takes priority over any redirect or handshake in the
  // same cycle. A redirect empties the FIFO and the in-flight PC queue.
  // A head popped in that cycle still counts as delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      fetch_pc       <= RESET_PC;
      occ            <= '0;
      outst          <= '0;
      drop           <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      pcq_wr         <= '0;
      pcq_rd         <= '0;
      misaligned_err <= 1'b0;
    end else begin
      state          <= state_n;
      outst          <= outst_n;
      drop           <= drop_n;
      misaligned_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);

      if (redirect_valid)
        fetch_pc <= redirect_pc & ~XLEN'(3);
      else if (accept)
        fetch_pc <= fetch_pc + XLEN'(4);

      if (redirect_valid) begin
        occ    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        pcq_wr <= '0;
        pcq_rd <= '0;
      end else begin
        if (accept) begin
          pcq[pcq_wr] <= fetch_pc;
          pcq_wr      <= pcq_wr + AW'(1);
        end
        if (push) begin
          fifo_pc[wr_ptr]    <= pcq[pcq_rd];
          fifo_instr[wr_ptr] <= imem_rsp_data;
          wr_ptr             <= wr_ptr + AW'(1);
          pcq_rd             <= pcq_rd + AW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)
          occ <= occ + CW'(1);
        else if (pop && !push)
          occ <= occ - CW'(1);
      end
    end
  end

  // The credit rule should make a push into a full FIFO impossible.
  always @(posedge clk) begin
    if (!rst && push)
      assert ({1'b0, occ} < DEPTH_W);
  end

endmodule
